// File: rtl/gpca_seq_unit.sv
// gpca_seq_unit: multi-cycle unsigned MUL / SQR / SQRT / DIV on one shared
// shift/add datapath. It retires one radix-2 step per clock and uses a
// START/BUSY/DONE handshake between the host register file and the result FIFO.
module gpca_seq_unit #(
    parameter int unsigned W = 9
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [2*W-1:0]   A,
    input  logic [W-1:0]     B,
    output logic             BUSY,
    output logic             DONE,
    output logic [2*W-1:0]   Q,
    output logic [W:0]       R,
    output logic             ERR
);

    localparam int unsigned W2 = 2 * W;           // double-width operand / result
    localparam int unsigned RW = W + 1;           // partial remainder width
    localparam int unsigned TW = W + 3;           // sqrt trial width (rem . 2 bits)
    localparam int unsigned CW = $clog2(W2 + 1);  // iteration counter width

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_SQR  = 2'b01;
    localparam logic [1:0] OP_SQRT = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t          state;
    logic [1:0]      op_r;
    logic [CW-1:0]   cnt;

    // Shared datapath registers; their meaning depends on op_r:
    //   acc : product (MUL/SQR), root in low W bits (SQRT), dividend->quotient (DIV)
    //   opa : shifted multiplicand (MUL/SQR), radicand shifted 2 bits/step (SQRT)
    //   opb : multiplier shifted right (MUL/SQR), divisor (DIV)
    //   rem : partial remainder (SQRT/DIV)
    logic [W2-1:0]   acc;
    logic [W2-1:0]   opa;
    logic [W-1:0]    opb;
    logic [RW-1:0]   rem;

    logic [W2-1:0]   acc_nxt;
    logic [W2-1:0]   opa_nxt;
    logic [W-1:0]    opb_nxt;
    logic [RW-1:0]   rem_nxt;

    logic [TW-1:0]   sq_t;
    logic [TW-1:0]   sq_trial;
    logic [RW-1:0]   dv_t;
    logic [RW-1:0]   dv_d;
    logic            last_step;

    assign last_step = (cnt == CW'(1));

    // One radix-2 iteration of the selected operation.
    always_comb begin
        acc_nxt  = acc;
        opa_nxt  = opa;
        opb_nxt  = opb;
        rem_nxt  = rem;
        sq_t     = {rem, opa[W2-1 -: 2]};
        sq_trial = {1'b0, acc[W-1:0], 2'b01};
        dv_t     = {rem[W-1:0], acc[W2-1]};
        dv_d     = {1'b0, opb};
        case (op_r)
            OP_MUL, OP_SQR: begin
                // LSB-first shift-add on the multiplier
                if (opb[0]) begin
                    acc_nxt = acc + opa;
                end
                opa_nxt = {opa[W2-2:0], 1'b0};
                opb_nxt = {1'b0, opb[W-1:1]};
            end
            OP_SQRT: begin
                // Restoring digit-by-digit: bring down 2 radicand bits, try (root<<2)|1
                if (sq_t >= sq_trial) begin
                    rem_nxt = RW'(sq_t - sq_trial);
                    acc_nxt = {acc[W2-2:0], 1'b1};
                end else begin
                    rem_nxt = RW'(sq_t);
                    acc_nxt = {acc[W2-2:0], 1'b0};
                end
                opa_nxt = {opa[W2-3:0], 2'b00};
            end
            default: begin
                // Restoring division: dividend MSB shifts into rem, quotient bit into acc LSB
                if (dv_t >= dv_d) begin
                    rem_nxt = dv_t - dv_d;
                    acc_nxt = {acc[W2-2:0], 1'b1};
                end else begin
                    rem_nxt = dv_t;
                    acc_nxt = {acc[W2-2:0], 1'b0};
                end
            end
        endcase
    end

    // Control FSM, operand capture, iteration and registered result outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            Q     <= '0;
            R     <= '0;
            ERR   <= 1'b0;
            op_r  <= OP_MUL;
            cnt   <= '0;
            acc   <= '0;
            opa   <= '0;
            opb   <= '0;
            rem   <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        op_r  <= OP;
                        rem   <= '0;
                        cnt   <= (OP == OP_DIV) ? CW'(W2) : CW'(W);
                        acc   <= (OP == OP_DIV) ? A : '0;
                        opa   <= (OP == OP_SQRT) ? A : {{W{1'b0}}, A[W-1:0]};
                        opb   <= (OP == OP_SQR) ? A[W-1:0] : B;
                        BUSY  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc <= acc_nxt;
                    opa <= opa_nxt;
                    opb <= opb_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt - CW'(1);
                    if (last_step) begin
                        state <= S_DONE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        case (op_r)
                            OP_MUL, OP_SQR: begin
                                Q   <= acc_nxt;
                                R   <= '0;
                                ERR <= 1'b0;
                            end
                            OP_SQRT: begin
                                Q   <= {{W{1'b0}}, acc_nxt[W-1:0]};
                                R   <= rem_nxt;
                                ERR <= 1'b0;
                            end
                            default: begin
                                // Divide by zero still runs full length, then reports all-ones
                                if (opb == '0) begin
                                    Q   <= '1;
                                    R   <= '0;
                                    ERR <= 1'b1;
                                end else begin
                                    Q   <= acc_nxt;
                                    R   <= {1'b0, rem_nxt[W-1:0]};
                                    ERR <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
